// File: rtl/foreground_pkg.sv
// foreground_pkg: shared types and VRAM map constants for the scanline sprite renderer.
// Also supplies a default VRAM_ADDR_WIDTH (12 bits, enough for 0x000-0x8FF) when the build does not set one.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
package foreground_pkg;
    localparam int PMF_BASE = 'h000;
    localparam int PMF_SIZE = 'h200;
    localparam int OBM_BASE = 'h800;
    localparam int OBM_SIZE = 'h100;
    // One OBM entry as stored in memory: byte 0 in the low bits.
    typedef struct packed {
        logic [4:0] rsv3;
        logic [2:0] color;
        logic       rsv2;
        logic       hflip;
        logic       vflip;
        logic [4:0] pmfa;
        logic [7:0] y;
        logic [7:0] x;
    } obm_obj_t;
    typedef struct packed {
        logic        en;
        logic [7:0]  x;
        logic [2:0]  color;
        logic [15:0] row;
    } slot_t;
    typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} fsm_e;
endpackage

// File: rtl/foreground_slot_m.sv
// foreground_slot_m: per-slot pixel lookup, plus the small helpers used around it.
//   foreground_slot_m : xp, slot -> pix[1:0] (0 = transparent), opaque
//   ffs_m             : v[W] -> idx of lowest set bit, found
//   pattern_hflipper_m: row[15:0], hflip -> out_row (pixel order mirrored when hflip)
module foreground_slot_m
    import foreground_pkg::*;
(
    input  logic [7:0] xp,
    input  slot_t      slot,
    output logic [1:0] pix,
    output logic       opaque
);
    logic [7:0] dx;
    assign dx = xp - slot.x;
    // Leftmost pixel lives in the top bits, so index with the inverted column.
    assign pix = (slot.en && dx[7:3] == 5'd0) ? slot.row[{~dx[2:0], 1'b0} +: 2] : 2'b00;
    assign opaque = |pix;
endmodule

module ffs_m #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  v,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) idx = v[i] ? IW'(i) : idx;
    end
    assign found = |v;
endmodule

module pattern_hflipper_m (
    input  logic [15:0] row,
    input  logic        hflip,
    output logic [15:0] out_row
);
    logic [15:0] m;
    for (genvar k = 0; k < 8; k++) begin : g_mir
        assign m[k*2 +: 2] = row[(7-k)*2 +: 2];
    end
    assign out_row = hflip ? m : row;
endmodule

// File: rtl/foreground_scanline.sv
// foreground_scanline: scanline-buffered sprite renderer with shadow/active slot banks.
//   clk, rst (async, active-low); xp/yp current pixel; line_start + next_yp start evaluation of a line;
//   frame_start clears sticky flags; writable/write_enable/address/data load PMF (0x000-) and OBM (0x800-);
//   r/g/b/valid registered pixel; overflow sticky slot overflow; collision sticky overlap.
//   FOREGROUND_COLLISION_EN enables the collision detector; otherwise collision is tied low.
module foreground_scanline
    import foreground_pkg::*;
#(
    parameter int NUM_OBJECTS  = 64,
    parameter int MAX_PER_LINE = 8,
    parameter int NUM_PATTERNS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  xp,
    input  logic [7:0]                  yp,
    input  logic                        line_start,
    input  logic [7:0]                  next_yp,
    input  logic                        frame_start,
    input  logic                        writable,
    input  logic [7:0]                  data,
    input  logic [`VRAM_ADDR_WIDTH-1:0] address,
    input  logic                        write_enable,
    output logic [1:0]                  r,
    output logic [1:0]                  g,
    output logic [1:0]                  b,
    output logic                        valid,
    output logic                        overflow,
    output logic                        collision
);
    localparam int OW = $clog2(NUM_OBJECTS);
    localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int PB = NUM_PATTERNS * 16;
    localparam int PW = $clog2(PB);
    localparam int BW = OW + 2;

    logic [7:0] pmf [PB];
    logic [7:0] obm [NUM_OBJECTS*4];
    logic       wen;
    assign wen = write_enable && writable;
    always_ff @(posedge clk) begin
        if (wen && int'(address) < PB) pmf[address[PW-1:0]] <= data;
        if (wen && int'(address) >= OBM_BASE && int'(address) < OBM_BASE + NUM_OBJECTS*4) obm[address[BW-1:0]] <= data;
    end

    fsm_e        state;
    logic [OW-1:0] idx;
    logic [7:0]  ny;
    logic [SW:0] cnt;
    logic [SW-1:0] fs;
    logic        ph;
    logic [7:0]  hi;
    slot_t       sh  [MAX_PER_LINE];
    slot_t       act [MAX_PER_LINE];
    logic [4:0]  f_pmfa [MAX_PER_LINE];
    logic [2:0]  f_row  [MAX_PER_LINE];
    logic        f_hf   [MAX_PER_LINE];

    obm_obj_t    obj;
    logic [7:0]  d;
    logic        take, ovf_set;
    assign obj = {obm[{idx, 2'd3}], obm[{idx, 2'd2}], obm[{idx, 2'd1}], obm[{idx, 2'd0}]};
    assign d = ny - obj.y;
    assign take = d[7:3] == 5'd0 && cnt != (SW+1)'(MAX_PER_LINE);
    assign ovf_set = !line_start && state == SCAN && d[7:3] == 5'd0 && cnt == (SW+1)'(MAX_PER_LINE);

    logic [7:0]  pbyte;
    logic [15:0] frow;
    assign pbyte = pmf[PW'({f_pmfa[fs], f_row[fs], ph})];
    pattern_hflipper_m u_flip (.row({hi, pbyte}), .hflip(f_hf[fs]), .out_row(frow));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            ny       <= '0;
            cnt      <= '0;
            fs       <= '0;
            ph       <= 1'b0;
            hi       <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
                sh[i]     <= '0;
                act[i]    <= '0;
                f_pmfa[i] <= '0;
                f_row[i]  <= '0;
                f_hf[i]   <= 1'b0;
            end
        end else begin
            overflow <= ovf_set ? 1'b1 : (frame_start ? 1'b0 : overflow);
            // line_start always swaps banks and restarts, whatever the evaluator was doing.
            if (line_start) begin
                state <= SCAN;
                ny    <= next_yp;
                idx   <= '0;
                cnt   <= '0;
                fs    <= '0;
                ph    <= 1'b0;
                for (int i = 0; i < MAX_PER_LINE; i++) begin
                    act[i] <= sh[i];
                    sh[i]  <= '0;
                end
            end else if (state == SCAN) begin
                if (take) begin
                    sh[cnt[SW-1:0]].x     <= obj.x;
                    sh[cnt[SW-1:0]].color <= obj.color;
                    f_pmfa[cnt[SW-1:0]]   <= obj.pmfa;
                    f_row[cnt[SW-1:0]]    <= d[2:0] ^ {3{obj.vflip}};
                    f_hf[cnt[SW-1:0]]     <= obj.hflip;
                    cnt                   <= cnt + 1'b1;
                end
                idx <= idx + 1'b1;
                if (idx == OW'(NUM_OBJECTS - 1)) state <= (cnt != '0 || take) ? FETCH : DONE;
            end else if (state == FETCH) begin
                ph <= ~ph;
                if (!ph) hi <= pbyte;
                else begin
                    // A slot becomes visible only once its pattern row is complete.
                    sh[fs].row <= frow;
                    sh[fs].en  <= 1'b1;
                    fs         <= fs + 1'b1;
                    if ({1'b0, fs} == cnt - 1'b1) state <= DONE;
                end
            end
        end
    end

    logic [1:0]              pix [MAX_PER_LINE];
    logic [MAX_PER_LINE-1:0] opq;
    logic [SW-1:0]           win;
    logic                    any;
    for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
        foreground_slot_m u_slot (.xp(xp), .slot(act[s]), .pix(pix[s]), .opaque(opq[s]));
    end
    ffs_m #(.W(MAX_PER_LINE), .IW(SW)) u_ffs (.v(opq), .idx(win), .found(any));

    logic [1:0] wp;
    logic [2:0] wc;
    assign wp = pix[win];
    assign wc = act[win].color;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            r     <= 2'b00;
            g     <= 2'b00;
            b     <= 2'b00;
        end else begin
            valid <= any;
            r     <= wp & {2{wc[2]}};
            g     <= wp & {2{wc[1]}};
            b     <= wp & {2{wc[0]}};
        end
    end

`ifdef FOREGROUND_COLLISION_EN
    logic multi;
    assign multi = |(opq & (opq - 1'b1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) collision <= 1'b0;
        else collision <= multi ? 1'b1 : (frame_start ? 1'b0 : collision);
    end
`else
    assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_foreground_scanline.sv
// tb_foreground_scanline: directed scoreboard bench for foreground_scanline.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif
module tb_foreground_scanline;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] xp = '0, yp = '0, next_yp = '0, data = '0;
    logic line_start = 1'b0, frame_start = 1'b0, writable = 1'b0, write_enable = 1'b0;
    logic [`VRAM_ADDR_WIDTH-1:0] address = '0;
    logic [1:0] r, g, b;
    logic valid, overflow, collision;
    int total = 0;
    int passed = 0;

    logic [7:0] m_pmf [512];
    logic [7:0] ox [64];
    logic [7:0] oy [64];
    logic [4:0] opat [64];
    logic       ohf [64];
    logic       ovf [64];
    logic [2:0] ocol [64];
    logic [6:0] sb [$];

    foreground_scanline dut (
        .clk(clk), .rst(rst), .xp(xp), .yp(yp), .line_start(line_start), .next_yp(next_yp),
        .frame_start(frame_start), .writable(writable), .data(data), .address(address),
        .write_enable(write_enable), .r(r), .g(g), .b(b), .valid(valid),
        .overflow(overflow), .collision(collision)
    );

    always #40 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic wr(input int a, input logic [7:0] v);
        @(negedge clk);
        address = `VRAM_ADDR_WIDTH'(a);
        data = v;
        writable = 1'b1;
        write_enable = 1'b1;
        @(negedge clk);
        writable = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic set_obj(input int i, input logic [7:0] x, input logic [7:0] y, input logic [4:0] pat,
                           input logic hf, input logic vf, input logic [2:0] col);
        ox[i] = x; oy[i] = y; opat[i] = pat; ohf[i] = hf; ovf[i] = vf; ocol[i] = col;
        wr('h800 + i*4, x);
        wr('h800 + i*4 + 1, y);
        wr('h800 + i*4 + 2, {1'b0, hf, vf, pat});
        wr('h800 + i*4 + 3, {5'd0, col});
    endtask

    task automatic hide(input int i);
        set_obj(i, 8'd0, 8'd200, 5'd0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic set_row(input int pat, input int row, input logic [15:0] v);
        m_pmf[pat*16 + row*2] = v[15:8];
        m_pmf[pat*16 + row*2 + 1] = v[7:0];
        wr(pat*16 + row*2, v[15:8]);
        wr(pat*16 + row*2 + 1, v[7:0]);
    endtask

    // Reference: first MAX_PER_LINE hits in index order, lowest index opaque pixel wins.
    function automatic logic [6:0] model(input logic [7:0] y, input logic [7:0] x);
        int n;
        logic [7:0] dy, dx, by;
        logic [2:0] ri, px;
        logic [1:0] p;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            dy = y - oy[i];
            if (dy < 8 && n < 8) begin
                n++;
                dx = x - ox[i];
                if (dx < 8) begin
                    ri = ovf[i] ? 3'd7 - dy[2:0] : dy[2:0];
                    px = ohf[i] ? 3'd7 - dx[2:0] : dx[2:0];
                    by = m_pmf[opat[i]*16 + ri*2 + (px[2] ? 1 : 0)];
                    p = by[(3 - px[1:0])*2 +: 2];
                    if (p != 2'b00) return {1'b1, p & {2{ocol[i][2]}}, p & {2{ocol[i][1]}}, p & {2{ocol[i][0]}}};
                end
            end
        end
        return 7'd0;
    endfunction

    task automatic pulse_ls(input logic [7:0] ny);
        @(negedge clk);
        next_yp = ny;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Drive one full line of xp; each expectation is checked one cycle later.
    task automatic sweep(input string tag, input logic [7:0] y, input bit blank);
        logic [6:0] e;
        sb.delete();
        for (int x = 0; x <= 256; x++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("%s y=%0d x=%0d", tag, y, x - 1), {25'd0, valid, r, g, b}, {25'd0, e});
            end
            if (x < 256) begin
                xp = 8'(x);
                yp = y;
                sb.push_back(blank ? 7'd0 : model(y, 8'(x)));
            end
        end
    endtask

    task automatic render(input string tag, input logic [7:0] y);
        pulse_ls(y);
        repeat (90) @(negedge clk);
        pulse_ls(y + 8'd1);
        sweep(tag, y, 1'b0);
    endtask

    initial begin
        logic c_exp;
`ifdef FOREGROUND_COLLISION_EN
        c_exp = 1'b1;
`else
        c_exp = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_r", {30'd0, r}, 0);
        chk("rst_g", {30'd0, g}, 0);
        chk("rst_b", {30'd0, b}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_collision", {31'd0, collision}, 0);
        rst = 1'b1;
        for (int i = 0; i < 512; i++) begin
            m_pmf[i] = 8'd0;
            wr(i, 8'd0);
        end
        for (int i = 0; i < 64; i++) hide(i);
        for (int i = 0; i < 8; i++) set_row(1, i, 16'hFFFF);

        // single object, plus its last row and the first row past it
        set_obj(0, 8'd10, 8'd20, 5'd1, 1'b0, 1'b0, 3'b100);
        render("t1", 8'd20);
        render("t1_last", 8'd27);
        render("t1_below", 8'd28);
        chk("t1_overflow", {31'd0, overflow}, 0);

        // nine objects on one line: ninth is dropped, overflow sticky until frame_start
        for (int i = 0; i < 9; i++) set_obj(i, 8'(i*24), 8'd5, 5'd1, 1'b0, 1'b0, 3'(i % 7 + 1));
        render("t2", 8'd5);
        chk("t2_overflow_set", {31'd0, overflow}, 1);
        pulse_fs();
        chk("t2_overflow_clr", {31'd0, overflow}, 0);
        for (int i = 0; i < 9; i++) hide(i);

        // overlap: lower index wins
        chk("t3_coll_pre", {31'd0, collision}, 0);
        set_obj(3, 8'd40, 8'd50, 5'd1, 1'b0, 1'b0, 3'b001);
        set_obj(7, 8'd40, 8'd50, 5'd1, 1'b0, 1'b0, 3'b010);
        render("t3", 8'd50);
        chk("t3_collision", {31'd0, collision}, {31'd0, c_exp});
        pulse_fs();
        chk("t3_coll_clr", {31'd0, collision}, 0);
        hide(3);
        hide(7);

        // x wrap, vflip, hflip, y wrap with a pattern of distinct rows
        for (int i = 0; i < 8; i++) set_row(2, i, 16'($urandom));
        set_obj(5, 8'd252, 8'd60, 5'd2, 1'b0, 1'b0, 3'b110);
        render("t4_wrapx", 8'd60);
        render("t4_row3", 8'd63);
        set_obj(5, 8'd252, 8'd60, 5'd2, 1'b0, 1'b1, 3'b110);
        render("t4_vflip", 8'd61);
        set_obj(5, 8'd252, 8'd60, 5'd2, 1'b1, 1'b0, 3'b011);
        render("t4_hflip", 8'd62);
        set_obj(5, 8'd100, 8'd254, 5'd2, 1'b1, 1'b1, 3'b101);
        render("t4_wrapy", 8'd1);
        hide(5);

        // restart mid-SCAN: partial bank (nothing fetched yet), then normal line
        set_obj(2, 8'd30, 8'd80, 5'd1, 1'b0, 1'b0, 3'b100);
        set_obj(50, 8'd100, 8'd80, 5'd1, 1'b0, 1'b0, 3'b010);
        pulse_ls(8'd80);
        repeat (20) @(negedge clk);
        pulse_ls(8'd80);
        sweep("t5_partial", 8'd80, 1'b1);
        pulse_ls(8'd81);
        sweep("t5_next", 8'd80, 1'b0);

        // reset during FETCH
        xp = 8'd30;
        pulse_ls(8'd82);
        repeat (2) @(negedge clk);
        chk("t6_pre_valid", {31'd0, valid}, 1);
        chk("t6_pre_r", {30'd0, r}, 3);
        repeat (63) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_valid", {31'd0, valid}, 0);
        chk("t6_r", {30'd0, r}, 0);
        chk("t6_overflow", {31'd0, overflow}, 0);
        chk("t6_collision", {31'd0, collision}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pulse_ls(8'd82);
        sweep("t6_after", 8'd82, 1'b1);
        render("t6_recover", 8'd83);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
